// File: rtl/nios_core_audio_i2s_tx_pkg.sv
// Shared constants, types and frame-assembly helper for the I2S DAC transmitter.
// Each frame is two 32-bit slots of 0 + 31 data bits.
package nios_core_audio_pkg;

  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;
  localparam int DEF_BCLK_DIV   = 6;
  localparam int DEF_SAMPLE_W   = 24;
  localparam int DEF_UCNT_W     = 16;

  typedef logic [I2S_FRAME_BITS-1:0] frame_t;
  typedef logic [I2S_SLOT_BITS-2:0]  slot_data_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_LOAD,
    EV_UNDERRUN
  } frame_ev_t;

  // The leading zero of each slot is the one-BCLK delay after the LRCLK edge.
  function automatic frame_t build_frame(input slot_data_t left, input slot_data_t right);
    return {1'b0, left, 1'b0, right};
  endfunction

endpackage

// File: rtl/nios_core_audio_i2s_tx_if.sv
// Sample-pair valid/ready channel feeding the I2S transmitter.
interface nios_core_audio_i2s_tx_if
  import nios_core_audio_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W
);
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_left;
  logic [SAMPLE_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/nios_core_audio_i2s_tx_clkdiv.sv
// BCLK divider and 64-bit frame position counter; fall_tick marks each BCLK falling edge.
module nios_core_audio_clkdiv
  import nios_core_audio_pkg::*;
#(
  parameter int BCLK_DIV = DEF_BCLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall_tick,
  output logic frame_start,
  output logic lrck_next
);
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(I2S_FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(BCLK_DIV / 2 - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [BIT_W-1:0] bit_cnt_next;
  logic             bclk_reg;

  assign fall_tick    = (div_cnt_reg == DIV_LAST);
  assign frame_start  = fall_tick & (bit_cnt_reg == '1);
  assign bit_cnt_next = bit_cnt_reg + 1'b1;
  assign lrck_next    = bit_cnt_next[BIT_W-1];
  assign bclk         = bclk_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else begin
      div_cnt_reg <= fall_tick ? '0 : div_cnt_reg + 1'b1;
      if (div_cnt_reg == DIV_RISE) begin
        bclk_reg <= 1'b1;
      end else if (fall_tick) begin
        bclk_reg <= 1'b0;
      end
      if (fall_tick) begin
        bit_cnt_reg <= bit_cnt_next;
      end
    end
  end

endmodule

// File: rtl/nios_core_audio_i2s_tx.sv
// I2S stereo DAC transmitter: lock synchroniser, 1-entry sample buffer,
// frame shift register and underrun accounting around the BCLK divider.
module nios_core_audio_i2s_tx
  import nios_core_audio_pkg::*;
#(
  parameter int BCLK_DIV = DEF_BCLK_DIV,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int UCNT_W   = DEF_UCNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pll_locked,
  nios_core_audio_i2s_tx_if.slave smp,
  output logic                    aud_bclk,
  output logic                    aud_daclrck,
  output logic                    aud_dacdat,
  output logic                    underrun,
  output logic [UCNT_W-1:0]       underrun_cnt
);
  localparam int PAD_W = I2S_SLOT_BITS - 1 - SAMPLE_W;

  logic [1:0]          lock_sync_reg;
  logic                int_rst;
  logic                fall_tick;
  logic                frame_start;
  logic                lrck_next;
  logic                transfer;
  logic                buf_full_reg;
  logic                buf_full_next;
  logic                s_ready_reg;
  logic [SAMPLE_W-1:0] buf_left_reg;
  logic [SAMPLE_W-1:0] buf_right_reg;
  frame_t              shift_reg;
  frame_t              load_frame;
  frame_ev_t           frame_ev;
  logic                lrck_reg;
  logic                dat_reg;
  logic                underrun_reg;
  logic [UCNT_W-1:0]   ucnt_reg;

  // pll_locked is asynchronous to clk; losing lock holds everything in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync_reg <= '0;
    end else begin
      lock_sync_reg <= {lock_sync_reg[0], pll_locked};
    end
  end

  assign int_rst = rst | ~lock_sync_reg[1];

  nios_core_audio_clkdiv #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clkdiv (
    .clk         (clk),
    .rst         (int_rst),
    .bclk        (aud_bclk),
    .fall_tick   (fall_tick),
    .frame_start (frame_start),
    .lrck_next   (lrck_next)
  );

  // A pair arriving on the frame-start edge itself waits for the next frame.
  always_comb begin
    frame_ev = EV_NONE;
    if (frame_start) begin
      frame_ev = buf_full_reg ? EV_LOAD : EV_UNDERRUN;
    end
    transfer      = smp.s_valid & s_ready_reg;
    buf_full_next = transfer | (buf_full_reg & (frame_ev != EV_LOAD));
    load_frame    = '0;
    if (frame_ev == EV_LOAD) begin
      load_frame = build_frame(slot_data_t'(buf_left_reg) << PAD_W,
                               slot_data_t'(buf_right_reg) << PAD_W);
    end
  end

  always_ff @(posedge clk) begin
    if (int_rst) begin
      buf_full_reg  <= 1'b0;
      s_ready_reg   <= 1'b0;
      buf_left_reg  <= '0;
      buf_right_reg <= '0;
      shift_reg     <= '0;
      lrck_reg      <= 1'b0;
      dat_reg       <= 1'b0;
      underrun_reg  <= 1'b0;
      ucnt_reg      <= '0;
    end else begin
      buf_full_reg <= buf_full_next;
      s_ready_reg  <= ~buf_full_next;
      underrun_reg <= (frame_ev == EV_UNDERRUN);
      if (transfer) begin
        buf_left_reg  <= smp.s_left;
        buf_right_reg <= smp.s_right;
      end
      if ((frame_ev == EV_UNDERRUN) && (ucnt_reg != '1)) begin
        ucnt_reg <= ucnt_reg + 1'b1;
      end
      // Data bit n of the frame leaves on the fall tick that moves bit_cnt to n.
      if (fall_tick) begin
        lrck_reg <= lrck_next;
        if (frame_start) begin
          dat_reg   <= load_frame[I2S_FRAME_BITS-1];
          shift_reg <= load_frame << 1;
        end else begin
          dat_reg   <= shift_reg[I2S_FRAME_BITS-1];
          shift_reg <= shift_reg << 1;
        end
      end
    end
  end

  assign smp.s_ready  = s_ready_reg;
  assign aud_daclrck  = lrck_reg;
  assign aud_dacdat   = dat_reg;
  assign underrun     = underrun_reg;
  assign underrun_cnt = ucnt_reg;

endmodule

// File: tb/tb_nios_core_audio_i2s_tx.sv
// Bench for nios_core_audio_i2s_tx: timeline model of the I2S stream checked every cycle,
// plus literal expectations for periods, a known frame, underrun counts and lock loss.
module tb_nios_core_audio_i2s_tx;
  localparam int D  = 6;
  localparam int SW = 24;
  localparam int UW = 16;
  localparam int FR = 64 * D;

  logic          clk;
  logic          rst;
  logic          pll_locked;
  logic          aud_bclk, aud_daclrck, aud_dacdat, underrun;
  logic [UW-1:0] underrun_cnt;
  logic          bclk2, lrck2, dat2, und2;
  logic [1:0]    ucnt2;

  nios_core_audio_i2s_tx_if #(.SAMPLE_W(SW)) bus ();
  nios_core_audio_i2s_tx_if #(.SAMPLE_W(SW)) bus2 ();

  nios_core_audio_i2s_tx #(.BCLK_DIV(D), .SAMPLE_W(SW), .UCNT_W(UW)) dut (
    .clk (clk), .rst (rst), .pll_locked (pll_locked), .smp (bus.slave),
    .aud_bclk (aud_bclk), .aud_daclrck (aud_daclrck), .aud_dacdat (aud_dacdat),
    .underrun (underrun), .underrun_cnt (underrun_cnt)
  );

  nios_core_audio_i2s_tx #(.BCLK_DIV(D), .SAMPLE_W(SW), .UCNT_W(2)) dut2 (
    .clk (clk), .rst (rst), .pll_locked (pll_locked), .smp (bus2.slave),
    .aud_bclk (bclk2), .aud_daclrck (lrck2), .aud_dacdat (dat2),
    .underrun (und2), .underrun_cnt (ucnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Left sample occupies frame bits 62..39, right sample bits 30..7.
  function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
    return ({40'd0, l} << 39) | ({40'd0, r} << 7);
  endfunction

  // Model state: m_t counts clk edges since the design last left reset.
  int          m_t = 0;
  bit          m_ir = 1'b1;
  bit          m_pend = 1'b0;
  logic [23:0] m_pl, m_pr;
  logic [63:0] m_frame = '0;
  bit          m_ready = 1'b0;
  bit          m_und = 1'b0;
  int          m_ucnt = 0;
  logic [63:0] cap = '0;
  bit          cap_done = 1'b0;
  int          und_seen = 0;

  initial begin
    bit lk1, lk2, xfer, e_bclk, e_lrck, e_dat;
    int p, f, n;
    logic [20:0] act, expv;
    lk1 = 1'b0;
    lk2 = 1'b0;
    forever begin
      @(posedge clk);
      xfer = bus.s_valid && m_ready;
      m_ir = rst || !lk2;
      if (rst) begin
        lk1 = 1'b0;
        lk2 = 1'b0;
      end else begin
        lk2 = lk1;
        lk1 = pll_locked;
      end
      if (m_ir) begin
        m_t = 0; m_pend = 1'b0; m_frame = '0; m_ready = 1'b0; m_und = 1'b0; m_ucnt = 0;
      end else begin
        m_t++;
        m_und = 1'b0;
        if (m_t % FR == 0) begin
          if (m_pend) begin
            m_frame = frame_of(m_pl, m_pr);
            m_pend  = 1'b0;
          end else begin
            m_frame = '0;
            m_und   = 1'b1;
            if (m_ucnt < (1 << UW) - 1) m_ucnt++;
          end
        end
        if (xfer) begin
          m_pend = 1'b1;
          m_pl   = bus.s_left;
          m_pr   = bus.s_right;
        end
        m_ready = !m_pend;
      end
      #1;
      if (m_ir) begin
        expv = '0;
      end else begin
        p = (m_t - 1) % D;
        f = m_t / D;
        n = f % 64;
        e_bclk = (p >= D / 2 - 1) && (p < D - 1);
        e_lrck = (n >= 32);
        e_dat  = m_frame[63 - n];
        expv = {e_bclk, e_lrck, e_dat, m_ready, m_und, UW'(m_ucnt)};
        if (m_t / FR == 1 && m_t % D == 0 && !cap_done) cap[63 - n] = aud_dacdat;
        if (m_t / FR == 2) cap_done = 1'b1;
      end
      act = {aud_bclk, aud_daclrck, aud_dacdat, bus.s_ready, underrun, underrun_cnt};
      check($sformatf("model t=%0d {bclk,lrck,dat,ready,und,cnt}", m_t), 64'(act), 64'(expv));
      if (underrun) und_seen++;
    end
  end

  task automatic wait_t(input int target);
    int guard = 0;
    while (m_t != target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("wait_t %0d reached", target), 64'(m_t), 64'(target));
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r);
    int guard = 0;
    bus.s_valid = 1'b1;
    bus.s_left  = l;
    bus.s_right = r;
    while (!bus.s_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("send accepted in time", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    $display("send L=%h R=%h accepted at t=%0d", l, r, m_t);
  endtask

  task automatic measure(input bit use_lrck, output int period, output int high);
    logic prev, cur;
    bit started = 1'b0;
    int c = 0;
    period = 0;
    high = 0;
    prev = use_lrck ? aud_daclrck : aud_bclk;
    for (int g = 0; g < 2000 && period == 0; g++) begin
      @(negedge clk);
      cur = use_lrck ? aud_daclrck : aud_bclk;
      if (!prev && cur) begin
        if (started) begin
          period = c;
        end else begin
          started = 1'b1;
          c = 0;
          high = 0;
        end
      end
      if (started && period == 0) begin
        c++;
        if (cur) high++;
      end
      prev = cur;
    end
  endtask

  // LRCLK period measured alongside the main stimulus.
  initial begin
    int per, hi;
    @(negedge clk);
    while (m_t < 1 && $time < 100000) @(negedge clk);
    measure(1'b1, per, hi);
    check("lrclk period", 64'(per), 64'd384);
    check("lrclk high", 64'(hi), 64'd192);
  end

  // Narrow counter instance never gets samples: every frame start underruns.
  initial begin
    wait_t(FR * 4 + 2);
    check("ucnt2 after 4 underruns", 64'(ucnt2), 64'd3);
    wait_t(FR * 5 + 2);
    check("ucnt2 after 5 underruns", 64'(ucnt2), 64'd3);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int per, hi, und_before;
    rst = 1'b1;
    pll_locked = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_left  = '0;
    bus.s_right = '0;
    bus2.s_valid = 1'b0;
    bus2.s_left  = '0;
    bus2.s_right = '0;
    repeat (10) @(negedge clk);
    check("reset outputs", 64'({aud_bclk, aud_daclrck, aud_dacdat, bus.s_ready, underrun, underrun_cnt}), 64'd0);
    rst = 1'b0;

    send(24'hA5A5A5, 24'h123456);
    bus.s_valid = 1'b0;
    measure(1'b0, per, hi);
    check("bclk period", 64'(per), 64'd6);
    check("bclk high", 64'(hi), 64'd3);

    for (int k = 0; k < 8; k++) begin
      send(24'hC00000 | 24'(k), ~(24'hC00000 | 24'(k)));
    end
    bus.s_valid = 1'b0;
    check("frame 1 bits", cap, 64'h52D2D280_091A2B00);

    wait_t(FR * 12 + 2);
    check("underrun_cnt after 3 empty frames", 64'(underrun_cnt), 64'd3);
    check("underrun pulses seen", 64'(und_seen), 64'd3);

    wait_t(FR * 13 - 1);
    bus.s_valid = 1'b1;
    bus.s_left  = 24'h7FFFFF;
    bus.s_right = 24'h800000;
    @(negedge clk);
    bus.s_valid = 1'b0;
    $display("race pair L=7fffff R=800000 offered on frame-start edge t=%0d", m_t);
    check("race underrun pulse", 64'(underrun), 64'd1);
    check("race underrun_cnt", 64'(underrun_cnt), 64'd4);
    check("race ready low", 64'(bus.s_ready), 64'd0);

    send(24'h123ABC, 24'hFEDCBA);
    bus.s_valid = 1'b0;
    wait_t(FR * 14 + 13);
    check("race pair left bit 22", 64'(aud_dacdat), 64'd1);

    wait_t(FR * 14 + 16 * D + 3);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    check("outputs zero after lock loss", 64'({aud_bclk, aud_daclrck, aud_dacdat, bus.s_ready, underrun, underrun_cnt}), 64'd0);
    repeat (20) @(negedge clk);
    pll_locked = 1'b1;
    und_before = und_seen;
    wait_t(FR - 1);
    check("no underrun in first frame after relock", 64'(und_seen - und_before), 64'd0);
    wait_t(FR + 2);
    check("buffered pair discarded on lock loss", 64'(underrun_cnt), 64'd1);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
